// File: rtl/rr_repeated_add_scheduler.sv
//==============================================================================
// Module      : rr_repeated_add_scheduler
// Description : Shared repeated-addition engine, x = b + a*k, one add per
//               cycle, fed by a two-client round-robin scheduler.
//               The controller walks IDLE -> LOAD -> ADD (k times) -> DONE.
// Ports       : clk      - clock, all state changes on posedge
//               reset_n  - asynchronous active-low reset
//               req0/1   - client job request, held with operands until gnt
//               a0/1     - client addend        (W bits)
//               b0/1     - client initial value (W bits)
//               k0/1     - client add count     (CW bits)
//               gnt0/1   - one-cycle pulse, job from that client accepted
//               busy     - high while the controller is not IDLE
//               done     - one-cycle pulse, x holds a finished result
//               done_id  - owner of the finished job, valid with done
//               x        - accumulator (W+CW bits), held until next LOAD
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_repeated_add_scheduler #(
    parameter int W  = 8,
    parameter int CW = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req0,
    input  logic [W-1:0]    a0,
    input  logic [W-1:0]    b0,
    input  logic [CW-1:0]   k0,
    input  logic            req1,
    input  logic [W-1:0]    a1,
    input  logic [W-1:0]    b1,
    input  logic [CW-1:0]   k1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic [W+CW-1:0] x
);

    // Result width: (2^W-1)*2^CW always fits, so the sum never wraps.
    localparam int XW = W + CW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ADD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [CW-1:0]   r_k;
    logic [CW-1:0]   r_cnt;
    logic            r_id;
    logic            r_last;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_busy;
    logic            r_done;
    logic            r_done_id;
    logic [XW-1:0]   r_x;

    logic            w_win;
    logic [CW-1:0]   w_cnt_nxt;

    // Contention goes to whoever did not win last; a lone request simply wins.
    assign w_win     = (req0 && req1) ? ~r_last : req1;

    // cnt only reaches k-1 before the compare, so cnt+1 never overflows CW bits.
    assign w_cnt_nxt = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_cnt     <= '0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_x       <= '0;
        end else begin
            // Pulse outputs fall back to zero unless a state below re-asserts them.
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_a     <= w_win ? a1 : a0;
                        r_b     <= w_win ? b1 : b0;
                        r_k     <= w_win ? k1 : k0;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                    end
                end

                S_LOAD: begin
                    r_x   <= {{CW{1'b0}}, r_b};
                    r_cnt <= '0;
                    if (r_k != '0) begin
                        r_state <= S_ADD;
                    end else begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end
                end

                S_ADD: begin
                    r_x   <= r_x + {{CW{1'b0}}, r_a};
                    r_cnt <= w_cnt_nxt;
                    if (w_cnt_nxt == r_k) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign x       = r_x;

endmodule

`default_nettype wire
